sha256_msg_padder: RTL and testbench
====================================

# sha256_msg_padder

Upstream stage of the SHA-256 core. Accepts an arbitrary-length byte message as a stream of 32-bit big-endian words with a valid/ready handshake. Appends the `1` bit, zero padding and the 64-bit big-endian bit length. Emits whole 512-bit blocks, with first/last flags, to the chunk-compression stage. Blocks are assembled directly in the output register, one word per cycle, with no extra block buffer.

## Interface
- `MAX_BYTES_W`, 61: width of the internal byte counter. The length field is `{byte_cnt, 3'b000}` zero-extended to 64 bits.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `s_valid` in 1: input word valid.
- `s_ready` out 1: padder can accept a word. Combinational: state==ACCEPT.
- `s_data` in 32: message word. Byte 0 sits at [31:24].
- `s_last` in 1: final word of the message.
- `s_nbytes` in 2: valid bytes in the final word, left-aligned. 0 means 4. Ignored unless `s_last`.
- `m_valid` out 1: `m_block` valid.
- `m_ready` in 1: downstream accepts the block.
- `m_block` out 512: padded block. Word 0 is at [511:480].
- `m_first` out 1: first block of the message. Downstream reloads the IV.
- `m_last` out 1: block carries the length field. Downstream finalises the hash.
- `busy` out 1: message in progress. Set on the first accepted word, cleared on the `m_last` handshake.

## Operation
- States: ACCEPT, PAD, LEN, EMIT. Reset state is ACCEPT.
- Word index `idx` runs 0..15.
- Flags:
  - `one_done`: the 0x80 marker has been written.
  - `len_pend`: the length has not yet been emitted.
  - `first_pend`: the next emitted block is the message's first.
- ACCEPT, on handshake:
  - Write `s_data` to word `idx`, with bytes beyond `s_nbytes` replaced per the rules below.
  - `byte_cnt += (s_last ? nbytes : 4)`.
  - `busy` is set.
  - Partial final word (nbytes 1..3): byte `nbytes` = 0x80, remaining bytes 0, `one_done`=1.
  - Full final word: `one_done`=0. The marker goes into the next word.
- After an ACCEPT write at idx 15 → EMIT.
  - If `s_last` was set, the return state is PAD; otherwise ACCEPT.
- After an `s_last` write at idx<15 → PAD.
- PAD writes one word per cycle at `idx`:
  - 0x80000000 if `!one_done` (then sets `one_done`).
  - 0x00000000 otherwise.
- Leaving PAD:
  - When `one_done` is set and the next idx is 14 → LEN.
  - When a PAD write lands on idx 15 → EMIT, with return state PAD. This covers the marker landing at idx 14 or 15.
- LEN writes `len[63:32]` to word 14, then `len[31:0]` to word 15. It then → EMIT with `m_last`=1 and return state ACCEPT.
- EMIT holds `m_valid`=1 and keeps `m_block`, `m_first`, `m_last` stable until the handshake.
- On the EMIT handshake edge:
  - `idx`=0, `m_valid`=0, `first_pend`=0.
  - If `m_last`: clear `byte_cnt`, `busy`, and flags; set `first_pend`=1.
- `m_first` = `first_pend` latched at EMIT entry.
- `byte_cnt` wraps modulo 2^MAX_BYTES_W. No error is flagged.
- Zero-length messages are unsupported. The minimum message is 1 byte.

## Timing
- Reset values:
  - `m_valid`=0, `m_block`=0, `m_first`=0, `m_last`=0, `busy`=0.
  - `s_ready`=1 (state ACCEPT).
  - `idx`=0, `byte_cnt`=0, `first_pend`=1.
- Reset asserted mid-message discards all partial state immediately, including a pending EMIT.
- `m_valid` rises on the same edge that writes word 15. There is zero added latency for full data blocks.
- The final block follows the `s_last` handshake edge by (15 − idx_last) edges.
- `s_ready` is 0 throughout PAD, LEN and EMIT. Input backpressure is total while a block is pending.
- `m_ready` is sampled only in EMIT. `m_ready` high outside EMIT has no effect.
- Throughput: one word per cycle in ACCEPT, plus ≥1 cycle per block in EMIT.

## Configuration
- `SHA_PAD_LE_INPUT_EN`, when defined:
  - `s_data` is little-endian, with byte 0 at [7:0]. It is byte-swapped before storage.
  - `s_nbytes` then counts bytes from [7:0] upward.
- When undefined, `s_data` is used as-is.
- The output format is identical in both builds.

## Test plan
- **"abc"**: word 0x61626300, nbytes=3, last.
  - One block: word0=0x61626380, words1..14=0, word15=0x00000018.
  - `m_first`=`m_last`=1. `m_valid` rises 15 edges after the input handshake.
- **55 bytes**: 13 full words, then word 13 with nbytes=3.
  - One block: word13 low byte=0x80, word15=0x000001B8.
- **56 bytes**: 14 full words, last with nbytes=0.
  - Block 1: word14=0x80000000, word15=0, `m_first`=1, `m_last`=0.
  - Block 2: words 0..14=0, word15=0x000001C0, `m_first`=0, `m_last`=1.
- **64 bytes**:
  - Block 1: data, `m_valid` on the 16th-word edge, `m_first`=1, `m_last`=0.
  - Block 2: word0=0x80000000, word15=0x00000200, `m_last`=1.
- **Backpressure**: hold `m_ready` low for 5 cycles during EMIT.
  - `m_block` and flags stay stable, `s_ready`=0.
  - Exactly one handshake occurs and no words are lost.
- **Reset mid-message**: pull `reset` low after 5 words, release, then send "abc".
  - Outputs match the "abc" case exactly, `m_first`=1, `busy` toggles correctly.
  - With `SHA_PAD_LE_INPUT_EN` defined, "abc" driven as 0x00636261 gives the identical block.

Source files
------------

// File: rtl/sha256_msg_padder_if.sv
// Byte-stream input and padded-block output bundle of the SHA-256 message padder.
interface sha256_msg_padder_if;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BLOCK_W = 512;

  logic               s_valid;
  logic               s_ready;
  logic [WORD_W-1:0]  s_data;
  logic               s_last;
  logic [1:0]         s_nbytes;
  logic               m_valid;
  logic               m_ready;
  logic [BLOCK_W-1:0] m_block;
  logic               m_first;
  logic               m_last;
  logic               busy;

  // Padder side.
  modport slave (
    input  s_valid, s_data, s_last, s_nbytes, m_ready,
    output s_ready, m_valid, m_block, m_first, m_last, busy
  );

  // Upstream source and downstream sink side.
  modport master (
    output s_valid, s_data, s_last, s_nbytes, m_ready,
    input  s_ready, m_valid, m_block, m_first, m_last, busy
  );
endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: appends marker, zero fill and bit length, emits 512-bit blocks.
// Optional macro SHA_PAD_LE_INPUT_EN: byte-swap little-endian input words before storage.
module sha256_msg_padder #(
  parameter int unsigned MAX_BYTES_W = 61
) (
  input logic                 clock,
  input logic                 reset,
  sha256_msg_padder_if.slave  bus
);
  localparam int unsigned WORD_W = 32;
  localparam int unsigned WORDS  = 16;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned LEN_W  = 64;

  typedef enum logic [1:0] {ACCEPT, PAD, LEN, EMIT} state_t;

  state_t                        state_q, state_d;
  state_t                        ret_q, ret_d;
  logic [IDX_W-1:0]              idx_q, idx_d, idx_inc;
  logic [MAX_BYTES_W-1:0]        byte_cnt_q, byte_cnt_d;
  logic                          one_done_q, one_done_d;
  logic                          len_pend_q, len_pend_d;
  logic                          first_pend_q, first_pend_d;
  logic                          m_valid_q, m_valid_d;
  logic                          m_first_q, m_first_d;
  logic                          m_last_q, m_last_d;
  logic                          busy_q, busy_d;
  logic [WORDS-1:0][WORD_W-1:0]  blk_q, blk_d;
  logic                          wr_en;
  logic [WORD_W-1:0]             wr_word;
  logic [WORD_W-1:0]             din;
  logic [2:0]                    nb;
  logic [LEN_W-1:0]              len_bits;

`ifdef SHA_PAD_LE_INPUT_EN
  assign din = {bus.s_data[7:0], bus.s_data[15:8], bus.s_data[23:16], bus.s_data[31:24]};
`else
  assign din = bus.s_data;
`endif

  assign nb       = (bus.s_nbytes == 2'd0) ? 3'd4 : {1'b0, bus.s_nbytes};
  assign len_bits = LEN_W'({byte_cnt_q, 3'b000});
  assign idx_inc  = idx_q + IDX_W'(1);

  // Next-state, word write and block-emit control.
  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    idx_d        = idx_q;
    byte_cnt_d   = byte_cnt_q;
    one_done_d   = one_done_q;
    len_pend_d   = len_pend_q;
    first_pend_d = first_pend_q;
    m_valid_d    = m_valid_q;
    m_first_d    = m_first_q;
    m_last_d     = m_last_q;
    busy_d       = busy_q;
    blk_d        = blk_q;
    wr_en        = 1'b0;
    wr_word      = '0;

    unique case (state_q)
      ACCEPT: begin
        if (bus.s_valid) begin
          wr_en      = 1'b1;
          busy_d     = 1'b1;
          len_pend_d = 1'b1;
          idx_d      = idx_inc;
          if (bus.s_last) begin
            byte_cnt_d = byte_cnt_q + MAX_BYTES_W'(nb);
            unique case (bus.s_nbytes)
              2'd1:    wr_word = {din[31:24], 24'h800000};
              2'd2:    wr_word = {din[31:16], 16'h8000};
              2'd3:    wr_word = {din[31:8], 8'h80};
              default: wr_word = din;
            endcase
            one_done_d = (bus.s_nbytes != 2'd0);
          end else begin
            byte_cnt_d = byte_cnt_q + MAX_BYTES_W'(4);
            wr_word    = din;
          end
          if (idx_q == IDX_W'(WORDS - 1)) begin
            state_d   = EMIT;
            ret_d     = bus.s_last ? PAD : ACCEPT;
            m_valid_d = 1'b1;
            m_first_d = first_pend_q;
            m_last_d  = 1'b0;
          end else if (bus.s_last) begin
            // A marker already in place with only the length words left skips PAD.
            state_d = (one_done_d && idx_inc == IDX_W'(14)) ? LEN : PAD;
          end
        end
      end
      PAD: begin
        wr_en      = 1'b1;
        wr_word    = one_done_q ? 32'h0000_0000 : 32'h8000_0000;
        one_done_d = 1'b1;
        idx_d      = idx_inc;
        if (idx_q == IDX_W'(WORDS - 1)) begin
          state_d   = EMIT;
          ret_d     = PAD;
          m_valid_d = 1'b1;
          m_first_d = first_pend_q;
          m_last_d  = 1'b0;
        end else if (idx_inc == IDX_W'(14)) begin
          state_d = LEN;
        end
      end
      LEN: begin
        wr_en   = 1'b1;
        wr_word = idx_q[0] ? len_bits[31:0] : len_bits[63:32];
        idx_d   = idx_inc;
        if (idx_q == IDX_W'(WORDS - 1)) begin
          state_d    = EMIT;
          ret_d      = ACCEPT;
          m_valid_d  = 1'b1;
          m_first_d  = first_pend_q;
          m_last_d   = len_pend_q;
          len_pend_d = 1'b0;
        end
      end
      EMIT: begin
        if (bus.m_ready) begin
          state_d      = ret_q;
          idx_d        = '0;
          m_valid_d    = 1'b0;
          first_pend_d = 1'b0;
          if (m_last_q) begin
            byte_cnt_d   = '0;
            busy_d       = 1'b0;
            one_done_d   = 1'b0;
            len_pend_d   = 1'b0;
            first_pend_d = 1'b1;
          end
        end
      end
      default: state_d = ACCEPT;
    endcase

    // Word 0 sits in the top slice, so word idx maps to slice 15-idx.
    if (wr_en) blk_d[~idx_q] = wr_word;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ACCEPT;
      ret_q        <= ACCEPT;
      idx_q        <= '0;
      byte_cnt_q   <= '0;
      one_done_q   <= 1'b0;
      len_pend_q   <= 1'b0;
      first_pend_q <= 1'b1;
      m_valid_q    <= 1'b0;
      m_first_q    <= 1'b0;
      m_last_q     <= 1'b0;
      busy_q       <= 1'b0;
      blk_q        <= '0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      idx_q        <= idx_d;
      byte_cnt_q   <= byte_cnt_d;
      one_done_q   <= one_done_d;
      len_pend_q   <= len_pend_d;
      first_pend_q <= first_pend_d;
      m_valid_q    <= m_valid_d;
      m_first_q    <= m_first_d;
      m_last_q     <= m_last_d;
      busy_q       <= busy_d;
      blk_q        <= blk_d;
    end
  end

  assign bus.s_ready = (state_q == ACCEPT);
  assign bus.m_valid = m_valid_q;
  assign bus.m_block = blk_q;
  assign bus.m_first = m_first_q;
  assign bus.m_last  = m_last_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder; input words are byte-swapped when SHA_PAD_LE_INPUT_EN is defined.
module tb_sha256_msg_padder;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   cnt;
  logic [31:0] ew [16];

  sha256_msg_padder_if bus ();

  sha256_msg_padder dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk512(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] drv(input logic [31:0] d);
`ifdef SHA_PAD_LE_INPUT_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  function automatic logic [7:0] mb(input int k);
    return 8'(k + 1);
  endfunction

  function automatic logic [31:0] mword(input int i);
    return {mb(4*i), mb(4*i+1), mb(4*i+2), mb(4*i+3)};
  endfunction

  function automatic logic [511:0] pack_ew();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[511-32*i -: 32] = ew[i];
    return r;
  endfunction

  task automatic clear_ew();
    for (int i = 0; i < 16; i++) ew[i] = 32'h0;
  endtask

  // One input word; returns at the negedge after its handshake edge.
  task automatic put(input logic [31:0] d, input logic last, input logic [1:0] nb);
    int n;
    n = 0;
    bus.s_valid  = 1'b1;
    bus.s_data   = drv(d);
    bus.s_last   = last;
    bus.s_nbytes = nb;
    while (!bus.s_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk1("s_ready", bus.s_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_valid(output int c);
    c = 0;
    while (!bus.m_valid && c < 40) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic chk_block(input string tag, input logic first, input logic last);
    chk1({tag, "_valid"}, bus.m_valid, 1'b1);
    chk512({tag, "_block"}, bus.m_block, pack_ew());
    chk1({tag, "_first"}, bus.m_first, first);
    chk1({tag, "_last"}, bus.m_last, last);
    chk1({tag, "_sready"}, bus.s_ready, 1'b0);
  endtask

  task automatic ack(input string tag);
    bus.m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.m_ready = 1'b0;
    chk1({tag, "_ack_valid"}, bus.m_valid, 1'b0);
  endtask

  task automatic run_abc(input string tag);
    put(32'h61626300, 1'b1, 2'd3);
    chk1({tag, "_busy_set"}, bus.busy, 1'b1);
    wait_valid(cnt);
    chk32({tag, "_latency"}, 32'(cnt), 32'd15);
    clear_ew();
    ew[0]  = 32'h61626380;
    ew[15] = 32'h00000018;
    chk_block(tag, 1'b1, 1'b1);
    ack(tag);
    chk1({tag, "_busy_clr"}, bus.busy, 1'b0);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    bus.s_valid  = 1'b0;
    bus.s_data   = 32'h0;
    bus.s_last   = 1'b0;
    bus.s_nbytes = 2'd0;
    bus.m_ready  = 1'b0;
    repeat (3) @(negedge clk);

    chk1("rst_mvalid", bus.m_valid, 1'b0);
    chk512("rst_block", bus.m_block, 512'h0);
    chk1("rst_first", bus.m_first, 1'b0);
    chk1("rst_last", bus.m_last, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_sready", bus.s_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // "abc": single block, marker in word 0
    run_abc("abc");

    // 55 bytes, junk in the dropped byte, with 5 cycles of output backpressure
    for (int i = 0; i < 13; i++) put(mword(i), 1'b0, 2'd0);
    put({mb(52), mb(53), mb(54), 8'hEE}, 1'b1, 2'd3);
    wait_valid(cnt);
    chk32("b55_latency", 32'(cnt), 32'd2);
    clear_ew();
    for (int i = 0; i < 13; i++) ew[i] = mword(i);
    ew[13] = {mb(52), mb(53), mb(54), 8'h80};
    ew[15] = 32'h000001B8;
    chk_block("b55", 1'b1, 1'b1);
    bus.s_valid = 1'b1;
    bus.s_data  = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_block("b55_hold", 1'b1, 1'b1);
    end
    bus.s_valid = 1'b0;
    ack("b55");
    chk1("b55_busy_clr", bus.busy, 1'b0);

    // 56 bytes: marker in word 14, length spills to a second block
    for (int i = 0; i < 13; i++) put(mword(i), 1'b0, 2'd0);
    put(mword(13), 1'b1, 2'd0);
    wait_valid(cnt);
    chk32("b56a_latency", 32'(cnt), 32'd2);
    clear_ew();
    for (int i = 0; i < 14; i++) ew[i] = mword(i);
    ew[14] = 32'h80000000;
    chk_block("b56a", 1'b1, 1'b0);
    ack("b56a");
    chk1("b56a_busy", bus.busy, 1'b1);
    wait_valid(cnt);
    chk32("b56b_latency", 32'(cnt), 32'd16);
    clear_ew();
    ew[15] = 32'h000001C0;
    chk_block("b56b", 1'b0, 1'b1);
    ack("b56b");

    // 64 bytes: data block emitted on the 16th-word edge, marker opens block 2
    for (int i = 0; i < 15; i++) put(mword(i), 1'b0, 2'd0);
    put(mword(15), 1'b1, 2'd0);
    chk1("b64a_now", bus.m_valid, 1'b1);
    clear_ew();
    for (int i = 0; i < 16; i++) ew[i] = mword(i);
    chk_block("b64a", 1'b1, 1'b0);
    ack("b64a");
    wait_valid(cnt);
    chk32("b64b_latency", 32'(cnt), 32'd16);
    clear_ew();
    ew[0]  = 32'h80000000;
    ew[15] = 32'h00000200;
    chk_block("b64b", 1'b0, 1'b1);
    ack("b64b");

    // Reset after 5 words, then "abc" again
    for (int i = 0; i < 5; i++) put(mword(i), 1'b0, 2'd0);
    chk1("mid_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_sready", bus.s_ready, 1'b1);
    chk1("mid_rst_busy", bus.busy, 1'b0);
    chk1("mid_rst_mvalid", bus.m_valid, 1'b0);
    chk512("mid_rst_block", bus.m_block, 512'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_abc("abc2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
